// File: rtl/mips_intr_ctrl_if.sv
// Interrupt-sequencer bundle between the pipeline/control side (master) and
// the interrupt controller (slave).
//
// Signal semantics: there is no valid/ready pair on this bundle. Interrupt is
// an asynchronous level whose rising edge is the request. Eret is a one-cycle
// pulse that is honoured only while In_Handler=1. Every controller output is a
// registered level that is valid for the whole cycle. Int_Ack is a one-cycle
// pulse that marks the cycle in which the request is taken.
interface mips_intr_ctrl_if #(
  parameter int PC_W = 8
);
  logic            Interrupt;
  logic            Int_En;
  logic            Branch_Pending;
  logic            Eret;
  logic [PC_W-1:0] PC_IF;
  logic            Stall;
  logic            Flush;
  logic            PC_Sel;
  logic [PC_W-1:0] PC_Vector;
  logic [PC_W-1:0] EPC;
  logic            In_Handler;
  logic            Int_Ack;
  logic            Pending;

  modport master (
    output Interrupt, Int_En, Branch_Pending, Eret, PC_IF,
    input  Stall, Flush, PC_Sel, PC_Vector, EPC, In_Handler, Int_Ack, Pending
  );

  modport slave (
    input  Interrupt, Int_En, Branch_Pending, Eret, PC_IF,
    output Stall, Flush, PC_Sel, PC_Vector, EPC, In_Handler, Int_Ack, Pending
  );
endinterface

// File: rtl/mips_intr_ctrl.sv
// Interrupt sequencer for the 8-bit pipelined MIPS core.
// The block synchronizes the Interrupt pin and edge-detects it into a Pending
// request. It defers entry while a branch is in EX. It then stalls and flushes
// the pipeline, saves EPC and redirects fetch to VECTOR. On Eret it redirects
// fetch back to EPC.
module mips_intr_ctrl #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] VECTOR      = 8'hF0,
  parameter int              SYNC_STAGES = 2
) (
  input  logic              Input_Clk,
  input  logic              Reset_n,
  mips_intr_ctrl_if.slave   bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_FLUSH   = 3'd2,
    S_VECTOR  = 3'd3,
    S_HANDLER = 3'd4,
    S_RETURN  = 3'd5
  } state_t;

  // The edge detector is armed only after prev_q holds a post-reset sample.
  // A level that is held high through reset is therefore not seen as a rise.
  localparam int FILL_MAX = SYNC_STAGES + 1;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   rise;

  state_t          state;
  state_t          state_nxt;
  logic            pending_q;
  logic [PC_W-1:0] epc_q;
  logic [PC_W-1:0] pc_vector_q;
  logic            stall_q;
  logic            flush_q;
  logic            pc_sel_q;
  logic            in_handler_q;
  logic            int_ack_q;

  // Synchronizer chain, previous-value flop and arming counter
  always_ff @(posedge Input_Clk) begin
    if (!Reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.Interrupt};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (fill_q != FILL_W'(FILL_MAX)) fill_q <= fill_q + FILL_W'(1);
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & (fill_q == FILL_W'(FILL_MAX));

  // Next-state rule. Eret matters only in HANDLER.
  function automatic state_t next_state(input state_t s, input logic pend,
                                        input logic en, input logic bp,
                                        input logic eret);
    state_t n;
    n = s;
    case (s)
      S_IDLE:    if (pend && en) n = bp ? S_WAIT : S_FLUSH;
      S_WAIT:    if (!en) n = S_IDLE; else if (!bp) n = S_FLUSH;
      S_FLUSH:   n = S_VECTOR;
      S_VECTOR:  n = S_HANDLER;
      S_HANDLER: if (eret) n = S_RETURN;
      S_RETURN:  n = S_IDLE;
      default:   n = S_IDLE;
    endcase
    return n;
  endfunction

  assign state_nxt = next_state(state, pending_q, bus.Int_En,
                                bus.Branch_Pending, bus.Eret);

  // FSM with outputs registered from the state being entered. As a result,
  // every output is a pure decode of the current state.
  always_ff @(posedge Input_Clk) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      pending_q    <= 1'b0;
      epc_q        <= '0;
      pc_vector_q  <= VECTOR;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      pc_sel_q     <= 1'b0;
      in_handler_q <= 1'b0;
      int_ack_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      // FLUSH consumes the request. A rise seen on that same edge is a new
      // request, so the rise wins.
      pending_q <= rise | (pending_q & (state != S_FLUSH));
      if (state == S_FLUSH) epc_q <= bus.PC_IF;
      // RETURN is entered only from HANDLER, so epc_q is already final here.
      pc_vector_q  <= (state_nxt == S_RETURN) ? epc_q : VECTOR;
      stall_q      <= (state_nxt == S_WAIT) || (state_nxt == S_FLUSH);
      flush_q      <= (state_nxt == S_FLUSH) || (state_nxt == S_RETURN);
      pc_sel_q     <= (state_nxt == S_VECTOR) || (state_nxt == S_RETURN);
      in_handler_q <= (state_nxt == S_HANDLER);
      int_ack_q    <= (state_nxt == S_FLUSH);
    end
  end

  assign bus.Stall      = stall_q;
  assign bus.Flush      = flush_q;
  assign bus.PC_Sel     = pc_sel_q;
  assign bus.PC_Vector  = pc_vector_q;
  assign bus.EPC        = epc_q;
  assign bus.In_Handler = in_handler_q;
  assign bus.Int_Ack    = int_ack_q;
  assign bus.Pending    = pending_q;
  assign dbg_state      = state;

endmodule
